// File: rtl/eq_serial_seq.sv
// Bit-serial word equality sequencer driving one shared 1-bit equality cell, LSB first.
// Optional build macro: EQ_SEQ_EARLY_EXIT_EN (finish as soon as a bit mismatches).
module eq_serial_seq #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             cmp_i0,
  output logic             cmp_i1,
  input  logic             cmp_eq
);

  typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH-1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             match_q, match_d;
  logic             eq_q, eq_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      match_q <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
      eq_q    <= eq_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    match_d = match_q;
    eq_d    = eq_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          cnt_d   = '0;
          match_d = 1'b1;
          eq_d    = 1'b0;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        match_d = match_q & cmp_eq;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        // eq is loaded on the way into DONE so it is already valid with the done pulse
        if (cnt_q == LAST) begin
          state_d = DONE;
          eq_d    = match_q & cmp_eq;
        end
`ifdef EQ_SEQ_EARLY_EXIT_EN
        if (!cmp_eq) begin
          state_d = DONE;
          eq_d    = 1'b0;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign eq     = eq_q;
  assign cmp_i0 = (state_q == COMPARE) & a_q[0];
  assign cmp_i1 = (state_q == COMPARE) & b_q[0];

endmodule
